// File: rtl/ahb_lite_slave_mem.sv
// ahb_lite_slave_mem: AHB-Lite slave backed by an internal word-organised memory.
// Fixed WAIT_STATES inserted in every OKAY data phase.
// Optional feature macro AHB_SLV_ERR_EN: compiles in transfer checks and the
// two-cycle ERROR response. Without it hresp is tied low, out-of-range
// addresses alias modulo MEM_DEPTH and oversize/misaligned beats are truncated.
module ahb_lite_slave_mem #(
   parameter int AHB_BUS_W   = 32,
   parameter int AHB_ADDR_W  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hsel,
   input  logic [AHB_ADDR_W-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [AHB_BUS_W-1:0]  hwdata,
   input  logic                  hready,
   output logic                  hreadyout,
   output logic [AHB_BUS_W-1:0]  hrdata,
   output logic                  hresp
);
   localparam int BYTES = AHB_BUS_W / 8;
   localparam int BL    = $clog2(BYTES);
   localparam int DL    = $clog2(MEM_DEPTH);
   localparam int BW2   = 2 * BYTES;
   localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t               state;
   logic [AHB_BUS_W-1:0] mem [MEM_DEPTH];
   logic [DL-1:0]        p_idx;
   logic [BYTES-1:0]     p_be;
   logic                 p_write;
   logic [2:0]           cnt;
   logic                 rdy_q;
   logic                 resp_q;

   logic                 accept;
   logic                 a_err;
   logic [DL-1:0]        a_idx;
   logic [BL-1:0]        a_off;
   logic [2:0]           sz_eff;
   logic [BW2-1:0]       be_wide;
   logic [BYTES-1:0]     a_be;

   assign accept = hsel & hready & htrans[1];
   assign a_idx  = haddr[BL +: DL];
   assign a_off  = haddr[BL-1:0];

   // Byte-lane enables: 2^size lanes from the byte offset, clipped at the word edge
   always_comb begin
      sz_eff  = (hsize > 3'(BL)) ? 3'(BL) : hsize;
      be_wide = (BW2'(1) << (4'd1 << sz_eff)) - BW2'(1);
      be_wide = be_wide << a_off;
      a_be    = be_wide[BYTES-1:0];
   end

`ifdef AHB_SLV_ERR_EN
   logic [AHB_ADDR_W-1:0] amask;
   logic                  unused_ok;
   assign amask     = (AHB_ADDR_W'(1) << hsize) - AHB_ADDR_W'(1);
   assign a_err     = (|(haddr >> (BL + DL))) | (hsize > 3'(BL)) | (|(haddr & amask));
   assign hresp     = resp_q;
   assign unused_ok = ^{hburst, htrans[0]};
`else
   logic unused_ok;
   assign a_err     = 1'b0;
   assign hresp     = 1'b0;
   assign unused_ok = ^{hburst, htrans[0], haddr, resp_q};
`endif

   assign hreadyout = rdy_q;
   // Read data is only presented in the completing cycle of a read; the
   // memory is read combinationally so a write committed at the address edge
   // of a following read is already visible.
   assign hrdata    = (state == S_DATA && !p_write) ? mem[p_idx] : '0;

   // Transfer FSM with registered hreadyout/hresp
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= 3'd0;
         p_idx   <= '0;
         p_be    <= '0;
         p_write <= 1'b0;
         rdy_q   <= 1'b1;
         resp_q  <= 1'b0;
      end else begin
         case (state)
            S_WAIT: begin
               if (cnt == WS_LAST) begin
                  state <= S_DATA;
                  cnt   <= 3'd0;
                  rdy_q <= 1'b1;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            S_ERR1: begin
               state  <= S_ERR2;
               rdy_q  <= 1'b1;
               resp_q <= 1'b1;
            end
            default: begin
               // IDLE, DATA and ERR2 all take a new address phase the same way
               cnt <= 3'd0;
               if (accept) begin
                  p_idx   <= a_idx;
                  p_be    <= a_be;
                  p_write <= hwrite & ~a_err;
                  if (a_err) begin
                     state  <= S_ERR1;
                     rdy_q  <= 1'b0;
                     resp_q <= 1'b1;
                  end else if (WAIT_STATES > 0) begin
                     state  <= S_WAIT;
                     rdy_q  <= 1'b0;
                     resp_q <= 1'b0;
                  end else begin
                     state  <= S_DATA;
                     rdy_q  <= 1'b1;
                     resp_q <= 1'b0;
                  end
               end else begin
                  state   <= S_IDLE;
                  p_write <= 1'b0;
                  rdy_q   <= 1'b1;
                  resp_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   // Write commit on the completing edge of an OKAY write data phase
   always_ff @(posedge clk) begin
      if (!reset && state == S_DATA && p_write) begin
         for (int b = 0; b < BYTES; b++) begin
            if (p_be[b]) mem[p_idx][8*b +: 8] <= hwdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// tb_ahb_lite_slave_mem: randomized AHB-Lite master against a byte-array
// reference memory; directed cases for reset, back-to-back and error handling.
module tb_ahb_lite_slave_mem;
   localparam int BW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 256;
   localparam int WS    = 2;
   localparam int BYTES = BW / 8;
   localparam int BL    = 2;

   typedef struct packed {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic          clk;
   logic          reset;
   logic          hsel;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [2:0]    hsize;
   logic [2:0]    hburst;
   logic [BW-1:0] hwdata;
   logic          hready;
   logic          hreadyout;
   logic [BW-1:0] hrdata;
   logic          hresp;

   int            n_chk = 0;
   int            n_err = 0;
   logic [7:0]    mem_m [DEPTH*BYTES];
   txn_t          q[$];
   logic [31:0]   last_rd;

   assign hready = hreadyout;

   ahb_lite_slave_mem #(
      .AHB_BUS_W(BW), .AHB_ADDR_W(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS)
   ) dut (
      .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hready(hready), .hreadyout(hreadyout), .hrdata(hrdata), .hresp(hresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_err(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_SLV_ERR_EN
      return (a >= 32'(DEPTH * BYTES)) || (s > 3'(BL)) || ((a % (32'd1 << s)) != 32'd0);
`else
      return (a === 32'hx) && (s === 3'hx);
`endif
   endfunction

   function automatic int m_widx(input logic [31:0] a);
      return int'((a / 32'(BYTES)) % 32'(DEPTH));
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
      int w   = m_widx(a);
      int off = int'(a % 32'(BYTES));
      int n   = 1 << ((s > 3'(BL)) ? BL : int'(s));
      for (int b = off; b < off + n && b < BYTES; b++) mem_m[w*BYTES + b] = wd[8*b +: 8];
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] r;
      int w = m_widx(a);
      for (int b = 0; b < BYTES; b++) r[8*b +: 8] = mem_m[w*BYTES + b];
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic txn_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                               input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
      txn_t t;
      t.sel = sel; t.trans = tr; t.wr = wr; t.size = sz; t.addr = a; t.wdata = wd;
      return t;
   endfunction

   function automatic txn_t rnd_txn();
      txn_t t;
      int k = int'($urandom_range(0, 9));
      t.sel   = 1'b1;
      t.trans = 2'b10 | 2'($urandom_range(0, 1));
      t.wr    = 1'($urandom_range(0, 1));
      t.size  = 3'($urandom_range(0, 2));
      t.wdata = $urandom;
      t.addr  = 32'($urandom_range(0, DEPTH*BYTES - 1)) & ~((32'd1 << t.size) - 32'd1);
      if (k == 0)      t.trans = 2'($urandom_range(0, 1));
      else if (k == 1) t.sel   = 1'b0;
      else if (k == 2) t.addr  = 32'($urandom_range(0, 2*DEPTH*BYTES - 1));
      else if (k == 3) t.size  = 3'($urandom_range(3, 7));
      return t;
   endfunction

   task automatic drive(input txn_t t);
      hsel   = t.sel;
      htrans = t.trans;
      hwrite = t.wr;
      hsize  = t.size;
      haddr  = t.addr;
      hburst = 3'($urandom_range(0, 7));
   endtask

   task automatic drive_slot(input int ai);
      if (ai < q.size()) drive(q[ai]);
      else drive(mk(1'b0, 2'b00, 1'b0, 3'd2, 32'd0, 32'd0));
   endtask

   // Pipelined master: runs every queued slot, checks each cycle against the model
   task automatic run();
      int   ai = 0;
      int   guard = 0;
      bit   dv = 0;
      int   dc = 0;
      int   nl;
      bit   de;
      logic rdy;
      txn_t d;
      d = '0;
      @(posedge clk); #1;
      drive_slot(0);
      while ((ai < q.size() || dv) && guard < 20000) begin
         @(negedge clk);
         rdy = hreadyout;
         if (dv) begin
            de = m_err(d.addr, d.size);
            nl = de ? 1 : WS;
            chk("hreadyout", 64'(hreadyout), 64'(dc >= nl));
            chk("hresp", 64'(hresp), 64'(de));
            if (!de && !d.wr && dc >= nl) begin
               chk("hrdata", 64'(hrdata), 64'(m_read(d.addr)));
               last_rd = hrdata;
            end else begin
               chk("hrdata_zero", 64'(hrdata), 64'd0);
            end
         end else begin
            chk("idle_hreadyout", 64'(hreadyout), 64'd1);
            chk("idle_hresp", 64'(hresp), 64'd0);
            chk("idle_hrdata", 64'(hrdata), 64'd0);
         end
         @(posedge clk);
         if (rdy) begin
            if (dv) begin
               if (d.wr && !m_err(d.addr, d.size)) m_write(d.addr, d.size, d.wdata);
               dv = 0;
            end
            if (ai < q.size()) begin
               if (q[ai].sel && q[ai].trans[1]) begin
                  d  = q[ai];
                  dv = 1;
                  dc = 0;
               end
               ai++;
            end
         end else if (dv) begin
            dc++;
         end
         #1;
         drive_slot(ai);
         hwdata = dv ? d.wdata : $urandom;
         guard++;
      end
      if (guard >= 20000) chk("run_timeout", 64'd1, 64'd0);
      q.delete();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset = 1'b1;
      hwdata = '0;
      last_rd = '0;
      drive(mk(1'b0, 2'b00, 1'b0, 3'd2, 32'd0, 32'd0));
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_hreadyout", 64'(hreadyout), 64'd1);
      chk("rst_hresp", 64'(hresp), 64'd0);
      chk("rst_hrdata", 64'(hrdata), 64'd0);

      // known contents for every word
      for (int i = 0; i < DEPTH; i++) q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'(i*4), $urandom));
      run();

      // back-to-back write/read, byte write, idle/busy/unselected slots
      q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
      q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
      run();
      chk("b2b_read", 64'(last_rd), 64'hDEADBEEF);
      q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd0, 32'h11, 32'h0000AA00));
      q.push_back(mk(1'b1, 2'b00, 1'b0, 3'd2, 32'h10, 32'h0));
      q.push_back(mk(1'b1, 2'b01, 1'b0, 3'd2, 32'h10, 32'h0));
      q.push_back(mk(1'b0, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
      q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
      run();
      chk("byte_merge", 64'(last_rd), 64'hDEADAAEF);

      // reset mid-way through a waited read
      @(posedge clk); #1;
      drive(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
      @(posedge clk); #1;
      drive(mk(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0));
      @(negedge clk);
      chk("pre_rst_wait", 64'(hreadyout), 64'd0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_hreadyout", 64'(hreadyout), 64'd1);
      chk("midrst_hresp", 64'(hresp), 64'd0);
      chk("midrst_hrdata", 64'(hrdata), 64'd0);
      q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
      run();
      chk("post_rst_read", 64'(last_rd), 64'hDEADAAEF);

      // reset during a pending write drops it
      @(posedge clk); #1;
      drive(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h0));
      @(posedge clk); #1;
      drive(mk(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0));
      hwdata = 32'hCAFEF00D;
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0));
      run();

      // out-of-range and misaligned transfers
      q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h000, 32'h0BADF00D));
      q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h400, 32'h12345678));
      q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd1, 32'h001, 32'h0));
      q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h000, 32'h0));
      run();
`ifdef AHB_SLV_ERR_EN
      chk("oor_no_write", 64'(last_rd), 64'h0BADF00D);
`else
      chk("oor_alias", 64'(last_rd), 64'h12345678);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) q.push_back(rnd_txn());
      run();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
